// File: rtl/op_dispatcher.sv
// Debounces a 3-bit mode code, launches the selected subsystem on confirm and tracks it until done.
// Optional RUN watchdog: define OP_DISPATCH_TIMEOUT_EN.
module op_dispatcher #(
  parameter int STABLE_CYCLES  = 16,
  parameter int BLINK_DIV      = 25000000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] op,
  input  logic       confirm,
  input  logic [4:0] done,
  output logic [4:0] start,
  output logic       busy,
  output logic [2:0] active_op,
  output logic [4:0] led,
  output logic       err
);

  if (STABLE_CYCLES < 2 || BLINK_DIV < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("op_dispatcher: STABLE_CYCLES and BLINK_DIV must be >= 2, TIMEOUT_CYCLES >= 1");
  end

  localparam int STAB_W  = $clog2(STABLE_CYCLES);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [STAB_W-1:0]  STAB_MAX  = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  function automatic logic [4:0] op_onehot(input logic [2:0] code);
    logic [4:0] oh;
    oh = '0;
    case (code)
      3'd1:    oh = 5'b00001;
      3'd2:    oh = 5'b00010;
      3'd3:    oh = 5'b00100;
      3'd4:    oh = 5'b01000;
      3'd5:    oh = 5'b10000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  state_t              r_state;
  logic [2:0]          r_op_q;
  logic [STAB_W-1:0]   r_stab_cnt;
  logic [2:0]          r_stable_op;
  logic [2:0]          r_active_op;
  logic                r_err;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_on;

  state_t              w_state_nxt;
  logic                w_same;
  logic [STAB_W-1:0]   w_stab_nxt;
  logic                w_stable_hit;
  logic [4:0]          w_stable_oh;
  logic [4:0]          w_active_oh;
  logic                w_stable_valid;
  logic                w_load_active;
  logic                w_err_set;
  logic [4:0]          w_start;
  logic                w_busy;
  logic [4:0]          w_led;

  // Counter holds (run length - 1) of identical samples, saturating at STABLE_CYCLES-1.
  assign w_same       = (op == r_op_q);
  assign w_stab_nxt   = !w_same                  ? '0 :
                        (r_stab_cnt == STAB_MAX) ? r_stab_cnt :
                                                   r_stab_cnt + STAB_W'(1);
  assign w_stable_hit = (w_stab_nxt == STAB_MAX);

  assign w_stable_oh    = op_onehot(r_stable_op);
  assign w_active_oh    = op_onehot(r_active_op);
  assign w_stable_valid = |w_stable_oh;

`ifdef OP_DISPATCH_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_expire;

  assign w_wd_expire = (r_state == S_RUN) && (r_wd_cnt == WD_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n || r_state != S_RUN) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_active = 1'b0;
    w_err_set     = 1'b0;
    w_start       = '0;
    w_busy        = 1'b0;
    w_led         = '0;
    unique case (r_state)
      S_IDLE: begin
        w_led = w_stable_valid ? w_stable_oh : {5{r_blink_on}};
        if (confirm) begin
          if (w_stable_valid) begin
            w_load_active = 1'b1;
            w_state_nxt   = S_START;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      S_START: begin
        w_busy      = 1'b1;
        w_start     = w_active_oh;
        w_led       = w_active_oh;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_led  = w_active_oh;
        if (|(done & w_active_oh)) begin
          w_state_nxt = S_IDLE;
        end
`ifdef OP_DISPATCH_TIMEOUT_EN
        else if (w_wd_expire) begin
          w_state_nxt = S_IDLE;
          w_err_set   = 1'b1;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; r_op_q keeps sampling during
  // reset so the sample taken on the reset edge is the first of the next stable run.
  always_ff @(posedge clk) begin
    r_op_q <= op;
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_stab_cnt  <= '0;
      r_stable_op <= '0;
      r_active_op <= '0;
      r_err       <= 1'b0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_err      <= w_err_set;
      if (w_stable_hit) begin
        r_stable_op <= op;
      end
      if (w_load_active) begin
        r_active_op <= r_stable_op;
      end
      if (r_blink_cnt == BLINK_MAX) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign start     = w_start;
  assign busy      = w_busy;
  assign active_op = r_active_op;
  assign led       = w_led;
  assign err       = r_err;

endmodule

// File: tb/tb_op_dispatcher.sv
// Scoreboard bench for op_dispatcher: a behavioural model pushes expected per-cycle outputs and
// launch events; an independent monitor pops and compares them on the falling edge.
module tb_op_dispatcher;

  localparam int STABLE = 4;
  localparam int BLINK  = 8;
  localparam int TMO    = 20;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [2:0] op      = '0;
  logic       confirm = 1'b0;
  logic [4:0] done    = '0;
  logic [4:0] start;
  logic       busy;
  logic [2:0] active_op;
  logic [4:0] led;
  logic       err;

  op_dispatcher #(
    .STABLE_CYCLES (STABLE),
    .BLINK_DIV     (BLINK),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .confirm  (confirm),
    .done     (done),
    .start    (start),
    .busy     (busy),
    .active_op(active_op),
    .led      (led),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] start;
    logic       busy;
    logic [2:0] act;
    logic [4:0] led;
    logic       err;
  } snap_t;

  snap_t      sb_q[$];
  logic [2:0] start_q[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [4:0] oh(input int code);
    return (code >= 1 && code <= 5) ? 5'(1 << (code - 1)) : 5'd0;
  endfunction

  // Reference model: mode 0 = idle, 1 = launching, 2 = running.
  int hist[$];
  int m_stable = 0;
  int m_mode   = 0;
  int m_active = 0;
  int m_since  = 0;
  int m_run    = 0;
  bit m_err    = 1'b0;

  task automatic model_edge(input logic rn, input int o, input logic c, input logic [4:0] d);
    int old_stable;
    bit same;
    if (!rn) begin
      hist.delete();
      hist.push_back(o);
      m_stable = 0; m_mode = 0; m_active = 0; m_since = 0; m_run = 0; m_err = 1'b0;
      return;
    end
    old_stable = m_stable;
    m_err      = 1'b0;
    hist.push_back(o);
    if (hist.size() > STABLE) void'(hist.pop_front());
    if (hist.size() == STABLE) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != o) same = 1'b0;
      if (same) m_stable = o;
    end
    case (m_mode)
      0: if (c) begin
        if (old_stable >= 1 && old_stable <= 5) begin
          m_active = old_stable;
          m_mode   = 1;
          start_q.push_back(3'(old_stable));
        end else begin
          m_err = 1'b1;
        end
      end
      1: begin
        m_mode = 2;
        m_run  = 0;
      end
      default: begin
        if (d[m_active-1]) begin
          m_mode = 0;
        end else begin
          m_run++;
`ifdef OP_DISPATCH_TIMEOUT_EN
          if (m_run >= TMO) begin
            m_mode = 0;
            m_err  = 1'b1;
          end
`endif
        end
      end
    endcase
    m_since++;
  endtask

  task automatic push_expected();
    snap_t e;
    e.busy  = (m_mode != 0);
    e.start = (m_mode == 1) ? oh(m_active) : 5'd0;
    e.act   = 3'(m_active);
    if (m_mode != 0)                      e.led = oh(m_active);
    else if (m_stable >= 1 && m_stable <= 5) e.led = oh(m_stable);
    else                                  e.led = ((m_since / BLINK) % 2 == 1) ? 5'h1f : 5'h00;
    e.err = m_err;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic rn, input logic [2:0] o, input logic c, input logic [4:0] d);
    rst_n   = rn;
    op      = o;
    confirm = c;
    done    = d;
    @(posedge clk);
    model_edge(rn, int'(o), c, d);
    #1 push_expected();
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic [2:0] o, input int n);
    repeat (n) step(1'b1, o, 1'b0, 5'd0);
  endtask

  task automatic do_reset(input logic [2:0] o);
    repeat (2) step(1'b0, o, 1'b0, 5'd0);
  endtask

  initial begin : monitor
    snap_t      e;
    logic [2:0] code;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("start",     start,     e.start);
        check("busy",      busy,      e.busy);
        check("active_op", active_op, e.act);
        check("led",       led,       e.led);
        check("err",       err,       e.err);
        if (start !== 5'd0) begin
          if (start_q.size() == 0) begin
            check("start_unexpected", start, 5'd0);
          end else begin
            code = start_q.pop_front();
            check("start_event", start, oh(int'(code)));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench time limit reached");
  end

  initial begin : driver
    int         cur_op;
    int         left;
    logic       rn;
    logic       c;
    logic [4:0] d;

    // op=3 held, confirm, launch, done
    do_reset(3'd3);
    hold(3'd3, 4);
    step(1'b1, 3'd3, 1'b1, 5'd0);
    hold(3'd3, 3);
    step(1'b1, 3'd3, 1'b0, 5'b00100);
    hold(3'd3, 2);

    // unstable op, confirm gives error only
    do_reset(3'd0);
    repeat (3) begin
      hold(3'd3, 2);
      hold(3'd4, 2);
    end
    step(1'b1, 3'd4, 1'b1, 5'd0);
    hold(3'd3, 3);

    // invalid op held: blink from reset release
    do_reset(3'd0);
    hold(3'd0, 40);

    // wrong done bits and op change while running
    do_reset(3'd2);
    hold(3'd2, 4);
    step(1'b1, 3'd2, 1'b1, 5'd0);
    step(1'b1, 3'd2, 1'b0, 5'b00010);
    repeat (3) step(1'b1, 3'd2, 1'b0, 5'b00001);
    hold(3'd5, 8);
    step(1'b1, 3'd5, 1'b1, 5'b00001);
    step(1'b1, 3'd5, 1'b0, 5'b00010);
    hold(3'd5, 3);

    // reset in the middle of RUN
    do_reset(3'd1);
    hold(3'd1, 4);
    step(1'b1, 3'd1, 1'b1, 5'd0);
    hold(3'd1, 4);
    step(1'b0, 3'd1, 1'b0, 5'd0);
    hold(3'd1, 2);

    // long RUN with no done (watchdog or indefinite wait)
    do_reset(3'd4);
    hold(3'd4, 4);
    step(1'b1, 3'd4, 1'b1, 5'd0);
    hold(3'd4, 110);

    // randomized traffic
    do_reset(3'd0);
    cur_op = 0;
    left   = 0;
    repeat (2500) begin
      if (left == 0) begin
        cur_op = $urandom_range(0, 7);
        left   = $urandom_range(1, 8);
      end
      left--;
      rn = ($urandom_range(0, 299) != 0);
      c  = ($urandom_range(0, 5) == 0);
      d  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      step(rn, 3'(cur_op), c, d);
    end

    @(negedge clk);
    #2;
    check("scoreboard_drain", sb_q.size(), 0);
    check("start_queue_drain", start_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
